// File: rtl/bt_vec_pkg.sv
// Shared constants for the vector operand path: frame geometry, loader
// state encodings and component slot indices used by the loader, the
// cross-product stage and the result serializer.
package bt_vec_pkg;

  localparam int BYTES_PER_COMP = 4;
  localparam int NUM_COMP       = 6;
  localparam int FRAME_BYTES    = BYTES_PER_COMP * NUM_COMP;
  localparam int COMP_W         = 8 * BYTES_PER_COMP;
  localparam int CNT_W          = $clog2(FRAME_BYTES);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_HOLD = 2'd2
  } ld_state_t;

  localparam int IDX_AX = 0;
  localparam int IDX_AY = 1;
  localparam int IDX_AZ = 2;
  localparam int IDX_BX = 3;
  localparam int IDX_BY = 4;
  localparam int IDX_BZ = 5;

endpackage

// File: rtl/frame_timeout_counter.sv
// Idle-cycle watchdog for a partially received frame.
// Latency: o_expired rises the cycle after the TIMEOUT_CYCLES-th enabled idle cycle.
// Backpressure: none; i_clr restarts the count, TIMEOUT_CYCLES=0 never expires.
// Ports: clk/rst (sync, active-high); i_clr clears; i_en counts; o_expired registered flag.
module frame_timeout_counter #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expired
);

  localparam int CW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] r_count;
  logic          r_expired;

  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_count   <= '0;
      r_expired <= 1'b0;
    end else if (i_en && (TIMEOUT_CYCLES > 0)) begin
      // Saturate so a stalled owner cannot wrap back into a fresh window.
      if (r_count != CW'(TIMEOUT_CYCLES)) begin
        r_count <= r_count + 1'b1;
      end
      r_expired <= (r_count == CW'(TIMEOUT_CYCLES - 1));
    end
  end

  assign o_expired = r_expired;

endmodule

// File: rtl/vector_frame_loader.sv
// Byte-serial loader: packs a 24-byte little-endian frame into six signed Q16.16 operands.
// Latency: out_valid one cycle after the last byte handshake; all outputs registered.
// Backpressure: in_ready is low while the set is held; released by out_valid && out_ready.
// Ports: clk/rst (sync, active-high); in_data/in_valid/in_sof/in_ready byte stream;
//        out_ax..out_bz/out_valid/out_ready operand set; frame_err pulse; busy (LOAD or HOLD).
module vector_frame_loader #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  input  logic        in_sof,
  output logic        in_ready,
  output logic [31:0] out_ax,
  output logic [31:0] out_ay,
  output logic [31:0] out_az,
  output logic [31:0] out_bx,
  output logic [31:0] out_by,
  output logic [31:0] out_bz,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        frame_err,
  output logic        busy
);

  import bt_vec_pkg::*;

  ld_state_t                        r_state;
  logic [CNT_W-1:0]                 r_cnt;
  logic [NUM_COMP-1:0][COMP_W-1:0]  r_comp;
  logic                             r_in_ready;
  logic                             r_out_valid;
  logic                             r_busy;
  logic                             r_err;

  logic       w_acc;
  logic       w_expired;
  logic       w_timeout;
  logic [2:0] w_comp_idx;
  logic [1:0] w_lane;

  assign w_acc      = in_valid && r_in_ready;
  assign w_timeout  = (r_state == ST_LOAD) && w_expired;
  // Four bytes per component: upper counter bits pick the slot, low bits the lane.
  assign w_comp_idx = r_cnt[CNT_W-1:2];
  assign w_lane     = r_cnt[1:0];

  frame_timeout_counter #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk       (clk),
    .rst       (rst),
    .i_clr     (w_acc || (r_state != ST_LOAD)),
    .i_en      (r_state == ST_LOAD),
    .o_expired (w_expired)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_comp      <= '0;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_err <= 1'b0;
      case (r_state)
        ST_IDLE, ST_LOAD: begin
          r_in_ready <= 1'b1;
          if (w_acc && in_sof) begin
            // Start or restart; an sof seen in LOAD (timed out or not) is one error.
            r_comp[IDX_AX][7:0] <= in_data;
            r_cnt               <= CNT_W'(1);
            r_state             <= ST_LOAD;
            r_busy              <= 1'b1;
            r_err               <= (r_state == ST_LOAD);
          end else if (w_timeout || (w_acc && (r_state == ST_IDLE))) begin
            // An expired frame makes this cycle behave as IDLE, so a stray
            // non-sof byte here is dropped under the same single error pulse.
            r_cnt   <= '0;
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_err   <= 1'b1;
          end else if (w_acc) begin
            r_comp[w_comp_idx][{w_lane, 3'b000} +: 8] <= in_data;
            r_cnt <= r_cnt + 1'b1;
            if (r_cnt == CNT_W'(FRAME_BYTES - 1)) begin
              r_cnt       <= '0;
              r_state     <= ST_HOLD;
              r_in_ready  <= 1'b0;
              r_out_valid <= 1'b1;
            end
          end
        end
        ST_HOLD: begin
          if (r_out_valid && out_ready) begin
            r_state     <= ST_IDLE;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_busy      <= 1'b0;
          end
        end
        default: begin
          r_state    <= ST_IDLE;
          r_busy     <= 1'b0;
          r_in_ready <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign busy      = r_busy;
  assign frame_err = r_err;
  assign out_ax    = r_comp[IDX_AX];
  assign out_ay    = r_comp[IDX_AY];
  assign out_az    = r_comp[IDX_AZ];
  assign out_bx    = r_comp[IDX_BX];
  assign out_by    = r_comp[IDX_BY];
  assign out_bz    = r_comp[IDX_BZ];

endmodule

// File: tb/tb_vector_frame_loader.sv
module tb_vector_frame_loader;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  in_data = 8'h00;
  logic        in_valid = 1'b0;
  logic        in_sof = 1'b0;
  logic        in_ready;
  logic [31:0] out_ax, out_ay, out_az, out_bx, out_by, out_bz;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        frame_err;
  logic        busy;

  always #5 clk = ~clk;

  vector_frame_loader #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst),
    .in_data(in_data), .in_valid(in_valid), .in_sof(in_sof), .in_ready(in_ready),
    .out_ax(out_ax), .out_ay(out_ay), .out_az(out_az),
    .out_bx(out_bx), .out_by(out_by), .out_bz(out_bz),
    .out_valid(out_valid), .out_ready(out_ready),
    .frame_err(frame_err), .busy(busy)
  );

  typedef struct {
    logic [5:0][31:0] c;
    int               cyc;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0, bad = 0;
  int   cyc = 0;
  int   exp_err = 0, obs_err = 0, frames_exp = 0, frames_seen = 0;
  bit   rdy_rand = 1'b0;

  // Reference model: stream of accepted bytes and idle cycles.
  logic [7:0] m_buf[$];
  bit         m_in = 1'b0;
  int         m_gap = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    if (rdy_rand) out_ready = ($urandom_range(3, 0) != 0);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  function automatic void m_idle();
    m_gap++;
    if (m_in && m_gap == TO) begin
      exp_err++;
      m_in = 1'b0;
    end
  endfunction

  function automatic void m_accept(input logic [7:0] b, input bit s, input int at);
    exp_t e;
    if (s) begin
      if (m_in) exp_err++;
      m_buf.delete();
      m_buf.push_back(b);
      m_in = 1'b1;
    end else if (!m_in) begin
      exp_err++;
    end else begin
      m_buf.push_back(b);
      if (m_buf.size() == 24) begin
        for (int k = 0; k < 6; k++)
          e.c[k] = {m_buf[4*k+3], m_buf[4*k+2], m_buf[4*k+1], m_buf[4*k]};
        e.cyc = at;
        exp_q.push_back(e);
        frames_exp++;
        m_in = 1'b0;
      end
    end
    m_gap = 0;
  endfunction

  task automatic tick_idle();
    in_valid = 1'b0;
    @(posedge clk); #1;
    m_idle();
  endtask

  task automatic send(input logic [7:0] b, input bit s);
    int g = 0;
    in_data = b; in_sof = s; in_valid = 1'b1;
    while (!in_ready) begin
      @(posedge clk); #1;
      m_idle();
      g++;
      if (g > 300) begin
        total++; bad++;
        $display("FAIL in_ready_wait: got 0 required 1 within 300 cycles");
        in_valid = 1'b0;
        return;
      end
    end
    @(posedge clk); #1;
    m_accept(b, s, cyc);
    in_valid = 1'b0; in_sof = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] b[24], input int gmax, input int upto);
    for (int i = 0; i < upto; i++) begin
      repeat ($urandom_range(gmax, 0)) tick_idle();
      send(b[i], i == 0);
    end
  endtask

  task automatic rand_frame(output logic [7:0] b[24]);
    for (int i = 0; i < 24; i++) b[i] = 8'($urandom);
  endtask

  task automatic release_one();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  // Monitor / scoreboard
  exp_t cur;
  bit   ov_q = 1'b0, hs_q = 1'b0;
  always @(negedge clk) begin
    if (rst) begin
      ov_q = 1'b0; hs_q = 1'b0;
    end else begin
      if (frame_err) obs_err++;
      if (hs_q) begin
        chk("ov_fall_after_hs", out_valid, 0);
        chk("ir_rise_after_hs", in_ready, 1);
        chk("busy_fall_after_hs", busy, 0);
      end
      if (out_valid && !ov_q) begin
        frames_seen++;
        if (exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_out_valid: got 1 required 0");
        end else begin
          cur = exp_q.pop_front();
          chk("out_valid_latency", cyc, cur.cyc);
        end
      end
      if (out_valid) begin
        chk("ax", out_ax, cur.c[0]); chk("ay", out_ay, cur.c[1]);
        chk("az", out_az, cur.c[2]); chk("bx", out_bx, cur.c[3]);
        chk("by", out_by, cur.c[4]); chk("bz", out_bz, cur.c[5]);
        chk("hold_in_ready", in_ready, 0);
        chk("hold_busy", busy, 1);
      end
      hs_q = out_valid && out_ready;
      ov_q = out_valid;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] fr[24];
    int e0;

    // Reset state
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 0); chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0); chk("rst_frame_err", frame_err, 0);
    chk("rst_ax", out_ax, 0); chk("rst_bz", out_bz, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("in_ready_after_rst", in_ready, 1);

    // 1. Basic frame
    for (int i = 0; i < 24; i++) fr[i] = 8'h00;
    fr[2] = 8'h01; fr[18] = 8'h02;
    send_frame(fr, 0, 24);
    chk("t1_out_valid", out_valid, 1);
    chk("t1_ax", out_ax, 32'h00010000); chk("t1_by", out_by, 32'h00020000);
    chk("t1_ay", out_ay, 0); chk("t1_az", out_az, 0);
    chk("t1_bx", out_bx, 0); chk("t1_bz", out_bz, 0);
    chk("t1_no_err", obs_err, 0);
    release_one();

    // 2. Sign handling
    for (int i = 0; i < 24; i++) fr[i] = 8'h00;
    fr[10] = 8'hFF; fr[11] = 8'hFF; fr[15] = 8'h80;
    send_frame(fr, 2, 24);
    chk("t2_az_bits", out_az, 32'hFFFF0000);
    chk("t2_az_neg", ($signed(out_az) == -65536), 1);
    chk("t2_bx_bits", out_bx, 32'h80000000);
    release_one();

    // 3. Backpressure: ten held cycles, then a single-cycle release
    rand_frame(fr);
    send_frame(fr, 1, 24);
    repeat (10) begin @(posedge clk); #1; end
    chk("t3_still_valid", out_valid, 1);
    release_one();
    chk("t3_ov_low", out_valid, 0);
    chk("t3_ir_high", in_ready, 1);

    // 4. Restart on byte 10
    rdy_rand = 1'b1;
    e0 = obs_err;
    rand_frame(fr);
    send_frame(fr, 1, 10);
    rand_frame(fr);
    send_frame(fr, 1, 24);
    repeat (30) tick_idle();
    chk("t4_one_err", obs_err - e0, 1);

    // 5a. Boundary: a 15-cycle gap must not time out
    e0 = obs_err;
    rand_frame(fr);
    send_frame(fr, 0, 5);
    repeat (TO - 1) tick_idle();
    for (int i = 5; i < 24; i++) send(fr[i], 1'b0);
    repeat (30) tick_idle();
    chk("t5_gap15_no_err", obs_err - e0, 0);

    // 5b. Timeout after a 16-cycle gap, then stray byte, then good frame
    e0 = obs_err;
    rand_frame(fr);
    send_frame(fr, 0, 5);
    repeat (TO + 3) tick_idle();
    chk("t5_busy_low", busy, 0);
    chk("t5_timeout_err", obs_err - e0, 1);
    send(8'h5A, 1'b0);
    repeat (3) tick_idle();
    chk("t5_drop_err", obs_err - e0, 2);
    rand_frame(fr);
    send_frame(fr, 2, 24);
    repeat (30) tick_idle();

    // 6. Mid-frame reset at byte 12
    rand_frame(fr);
    send_frame(fr, 1, 12);
    rst = 1'b1;
    repeat (2) begin
      @(posedge clk); #1;
      chk("t6_ir", in_ready, 0); chk("t6_ov", out_valid, 0);
      chk("t6_busy", busy, 0);   chk("t6_err", frame_err, 0);
      chk("t6_ax", out_ax, 0);   chk("t6_ay", out_ay, 0);
      chk("t6_az", out_az, 0);   chk("t6_bx", out_bx, 0);
      chk("t6_by", out_by, 0);   chk("t6_bz", out_bz, 0);
    end
    rst = 1'b0;
    m_in = 1'b0; m_buf.delete(); m_gap = 0;
    rand_frame(fr);
    send_frame(fr, 1, 24);

    // Random traffic with occasional stray bytes
    for (int n = 0; n < 10; n++) begin
      if ($urandom_range(3, 0) == 0) send(8'($urandom), 1'b0);
      rand_frame(fr);
      send_frame(fr, 3, 24);
    end

    // Drain
    for (int w = 0; w < 500 && exp_q.size() != 0; w++) tick_idle();
    repeat (5) tick_idle();
    chk("drain_queue_empty", exp_q.size(), 0);
    chk("frames_seen", frames_seen, frames_exp);
    chk("err_total", obs_err, exp_err);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vector_frame_loader.md
Name: vector_frame_loader

Overview:
Byte-serial operand loader that sits directly upstream of the vector cross-product stage. It receives a 24-byte frame over an 8-bit valid/ready stream and assembles six signed Q16.16 components (Ax, Ay, Az, Bx, By, Bz). It then presents them as a held, registered operand set with an out_valid/out_ready handshake. It also guards frame integrity with start-of-frame sync and an inter-byte timeout.

Parameters:
BYTES_PER_COMP, 4, bytes per Q16.16 component; fixed at 4, other values unsupported.
NUM_COMP, 6, components per frame (A then B, x/y/z each).
TIMEOUT_CYCLES, 16, idle cycles allowed between accepted bytes mid-frame; 0 disables the timeout.

Ports:
clk  input  1  single clock; all state updates on its rising edge
rst  input  1  reset, synchronous, active-high
in_data  input  8  frame byte
in_valid  input  1  in_data valid
in_sof  input  1  qualifies in_data as byte 0 of a frame
in_ready  output  1  loader accepts a byte this cycle
out_ax, out_ay, out_az  output  32 each  signed Q16.16 A components
out_bx, out_by, out_bz  output  32 each  signed Q16.16 B components
out_valid  output  1  operand set complete and stable
out_ready  input  1  downstream consumes the operand set
frame_err  output  1  one-cycle pulse on a discarded or illegal byte/frame
busy  output  1  high in LOAD or HOLD

Behaviour:
- Reset: all component registers 0; out_valid=0, frame_err=0, busy=0, in_ready=0 while rst=1; state=IDLE, byte counter=0, timeout counter=0. in_ready rises the first cycle after rst deasserts. Reset mid-frame discards everything.
- Byte accept: a byte is accepted on any cycle with in_valid && in_ready.
- Frame format: 24 bytes, component order Ax, Ay, Az, Bx, By, Bz. Each component is little-endian, so byte 4k+0 goes to bits [7:0] and byte 4k+3 to bits [31:24].
- Byte addressing: byte index n writes component n/4, byte lane n%4.

State machine:
- IDLE (in_ready=1):
  - Accepted byte with in_sof=1: store it as byte 0, counter=1, go to LOAD.
  - Accepted byte with in_sof=0: drop it, pulse frame_err next cycle, stay in IDLE.
- LOAD (in_ready=1):
  - Accepted byte with in_sof=0: store at counter, counter+1.
  - Accepted byte with in_sof=1: restart. Pulse frame_err, store the byte as byte 0, counter=1, stay in LOAD. Previously loaded lanes are don't-care because they are overwritten before completion.
  - When byte 23 is accepted: go to HOLD. out_valid=1 the next cycle (latency 1 from the last handshake).
  - Timeout (TIMEOUT_CYCLES>0): the counter clears on each accepted byte and increments otherwise. When it reaches TIMEOUT_CYCLES, go to IDLE, pulse frame_err, counter=0.
- HOLD (in_ready=0, out_valid=1):
  - Outputs are frozen.
  - On out_valid && out_ready: go to IDLE next cycle. out_valid falls and in_ready rises that same next cycle.
  - No timeout in HOLD.
- Busy and throughput: busy = (state != IDLE). Minimum frame-to-frame period is 25 cycles (24 bytes + 1 HOLD cycle with out_ready tied high).
- Output validity: outputs are the assembly registers and are only meaningful while out_valid=1. The bench must not check them otherwise.
- frame_err: registered single-cycle pulse. Two error causes in the same cycle still give one pulse.
- Arithmetic: no arithmetic; bit-exact byte packing. Sign comes solely from byte 3 of each component.

Decomposition:
- Shared include/package bt_vec_pkg:
  - localparams BYTES_PER_COMP=4, NUM_COMP=6, FRAME_BYTES=24.
  - State encodings ST_IDLE, ST_LOAD, ST_HOLD.
  - Component index constants IDX_AX..IDX_BZ, reused by the cross-product and result-serializer stages.
- One natural sub-module, frame_timeout_counter: clear/enable inputs, TIMEOUT_CYCLES parameter, registered expired output.

Test Plan:
1. Basic frame: reset, then a frame with Ax=0x00010000 (bytes 00 00 01 00) and By=0x00020000, all others 0. Required: out_valid the cycle after byte 23, out_ax=0x00010000, out_by=0x00020000, rest 0, frame_err never set.
2. Sign handling: Az=0xFFFF0000 (bytes 00 00 FF FF) and Bx=0x80000000. Required: out_az=-65536, out_bx=-2147483648, exact bits.
3. Backpressure: hold out_ready=0 for 10 cycles after out_valid. Required: out_valid, busy and all outputs stable, in_ready=0. Then out_ready=1 for 1 cycle: next cycle out_valid=0, in_ready=1.
4. Restart: in_sof=1 on byte 10. Required: one frame_err pulse; out_valid only after 23 further bytes, carrying the second frame's data.
5. Timeout and idle error: 5 bytes then a 16-cycle gap (TIMEOUT_CYCLES=16). Required: frame_err pulse and busy=0. Then a byte with in_sof=0 is dropped with a frame_err pulse, and a following complete frame loads correctly.
6. Mid-frame reset: rst=1 for 2 cycles at byte 12. Required: in_ready=0, out_valid=0, busy=0 during reset, all outputs 0. A fresh frame afterwards completes normally with no stale bytes.
